// File: rtl/arqui_pkg.sv
// Shared definitions for the arqui output-side reader: FSM encoding, word and
// counter widths, channel count and a one-hot to index helper.
package arqui_pkg;

    localparam int          DATA_SIZE = 6;
    localparam int          CNT_SIZE  = 5;
    localparam int unsigned NUM_CH    = 4;

    typedef enum logic [1:0] {
        RESET  = 2'd0,
        INIT   = 2'd1,
        IDLE   = 2'd2,
        ACTIVE = 2'd3
    } state_t;

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        case (oh)
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: grants the first requester at or after ptr,
// wrapping mod 4.
module rr_arbiter4 (
    input  logic [3:0] req_mask,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic       any
);
    import arqui_pkg::*;

    logic [1:0] ch;
    logic       found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        ch    = ptr;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch = ptr + 2'(i);
            if (!found && req_mask[ch]) begin
                grant[ch] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any = |req_mask;

endmodule

// File: rtl/arqui_lector.sv
// Round-robin drain of the four arqui output FIFOs with per-channel word
// counters and a one-cycle counter read port.
module arqui_lector #(
    parameter int DATA_SIZE = arqui_pkg::DATA_SIZE,
    parameter int CNT_SIZE  = arqui_pkg::CNT_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic                 pause,
    input  logic [3:0]           empty_i,
    input  logic [DATA_SIZE-1:0] data_i0,
    input  logic [DATA_SIZE-1:0] data_i1,
    input  logic [DATA_SIZE-1:0] data_i2,
    input  logic [DATA_SIZE-1:0] data_i3,
    output logic [3:0]           pop_o,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic [1:0]           idx_out,
    input  logic                 req,
    input  logic [1:0]           idx,
    output logic                 cnt_valid,
    output logic [CNT_SIZE-1:0]  cnt_out,
    output logic                 idle_out
);
    import arqui_pkg::*;

    state_t               state_q;
    logic                 idle_q;
    logic [1:0]           rr_ptr_q;
    logic                 pend_vld_q;
    logic [1:0]           pend_idx_q;
    logic [DATA_SIZE-1:0] data_q;
    logic                 valid_q;
    logic [1:0]           idx_q;
    logic [CNT_SIZE-1:0]  count_q [NUM_CH];
    logic                 cnt_valid_q;
    logic [CNT_SIZE-1:0]  cnt_q;

    logic [3:0]           grant;
    logic                 arb_any;
    logic [3:0]           pop;
    logic [1:0]           pop_idx;
    logic [DATA_SIZE-1:0] cap_data;

    rr_arbiter4 u_arb (
        .req_mask (~empty_i),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .any      (arb_any)
    );

    // pause gates the pop in the same cycle, independent of the FSM state register
    assign pop     = (state_q == ACTIVE && !pause && arb_any) ? grant : '0;
    assign pop_idx = onehot_idx(pop);

    always_comb begin
        case (pend_idx_q)
            2'd1:    cap_data = data_i1;
            2'd2:    cap_data = data_i2;
            2'd3:    cap_data = data_i3;
            default: cap_data = data_i0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= RESET;
            idle_q  <= 1'b0;
        end else if (state_q == RESET || init) begin
            state_q <= INIT;
            idle_q  <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    state_q <= IDLE;
                    idle_q  <= 1'b1;
                end
                IDLE: begin
                    if (!(&empty_i) && !pause) begin
                        state_q <= ACTIVE;
                        idle_q  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if ((&empty_i) || pause) begin
                        state_q <= IDLE;
                        idle_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= INIT;
                    idle_q  <= 1'b0;
                end
            endcase
        end
    end

    // An in-flight capture always completes; only its count is dropped while in INIT.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rr_ptr_q    <= '0;
            pend_vld_q  <= 1'b0;
            pend_idx_q  <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            cnt_valid_q <= 1'b0;
            cnt_q       <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            pend_vld_q <= |pop;
            pend_idx_q <= pop_idx;
            valid_q    <= pend_vld_q;
            if (|pop) begin
                rr_ptr_q <= pop_idx + 2'd1;
            end
            if (pend_vld_q) begin
                data_q <= cap_data;
                idx_q  <= pend_idx_q;
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (state_q == INIT) begin
                    count_q[i] <= '0;
                end else if (pend_vld_q && pend_idx_q == 2'(i)) begin
                    count_q[i] <= count_q[i] + CNT_SIZE'(1);
                end
            end
            cnt_valid_q <= req;
            if (req) begin
                cnt_q <= (state_q == INIT) ? '0 : count_q[idx];
            end
        end
    end

    assign pop_o     = pop;
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign idx_out   = idx_q;
    assign cnt_valid = cnt_valid_q;
    assign cnt_out   = cnt_q;
    assign idle_out  = idle_q;

endmodule

// File: tb/tb_arqui_lector.sv
// Bench for arqui_lector: behavioural FIFOs feed the reader, a scoreboard holds
// the expected word order and each task checks one scenario.
module tb_arqui_lector;

    localparam int DW = 6;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          init;
    logic          pause;
    logic          req;
    logic [1:0]    idx;
    logic [3:0]    empty_i = '1;
    logic [DW-1:0] dq [4] = '{default: '0};
    logic [3:0]    pop_o;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [1:0]    idx_out;
    logic          cnt_valid;
    logic [CW-1:0] cnt_out;
    logic          idle_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] fq [4][$];
    logic [DW+1:0] sb [$];
    logic [3:0]    pop_log [$];
    logic [1:0]    model_ptr = 2'd0;
    logic [DW+1:0] mon_exp;

    arqui_lector #(.DATA_SIZE(DW), .CNT_SIZE(CW)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .init      (init),
        .pause     (pause),
        .empty_i   (empty_i),
        .data_i0   (dq[0]),
        .data_i1   (dq[1]),
        .data_i2   (dq[2]),
        .data_i3   (dq[3]),
        .pop_o     (pop_o),
        .data_out  (data_out),
        .valid_out (valid_out),
        .idx_out   (idx_out),
        .req       (req),
        .idx       (idx),
        .cnt_valid (cnt_valid),
        .cnt_out   (cnt_out),
        .idle_out  (idle_out)
    );

    always #5 clk = ~clk;

    // FIFO model: read data appears the cycle after a pop.
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (pop_o[n]) begin
                n_cmp++;
                if (fq[n].size() == 0) begin
                    n_err++;
                    $display("FAIL pop_empty: ch%0d popped with fifo size 0, required non-empty", n);
                end else begin
                    dq[n] <= fq[n].pop_front();
                end
            end
        end
        if (pop_o != 4'b0) pop_log.push_back(pop_o);
        for (int n = 0; n < 4; n++) empty_i[n] <= (fq[n].size() == 0);
    end

    always @(negedge clk) begin
        if (reset_L === 1'b1 && valid_out === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL word: got idx=%0d data=%h, required no output", idx_out, data_out);
            end else begin
                mon_exp = sb.pop_front();
                if ({idx_out, data_out} !== mon_exp) begin
                    n_err++;
                    $display("FAIL word: got idx=%0d data=%h, required idx=%0d data=%h",
                             idx_out, data_out, mon_exp[DW+1:DW], mon_exp[DW-1:0]);
                end
            end
        end
    end

    // Round-robin reference: expected order for draining everything queued now.
    function automatic void build_expected();
        logic [DW-1:0] cp [4][$];
        logic [1:0]    p;
        logic [1:0]    ch;
        bit            found;
        int            total;
        p = model_ptr;
        total = 0;
        for (int n = 0; n < 4; n++) begin
            cp[n] = fq[n];
            total += fq[n].size();
        end
        for (int k = 0; k < total; k++) begin
            found = 1'b0;
            for (int s = 0; s < 4; s++) begin
                ch = p + 2'(s);
                if (!found && cp[ch].size() != 0) begin
                    sb.push_back({ch, cp[ch].pop_front()});
                    found = 1'b1;
                end
            end
            for (int s = 0; s < 4; s++) begin
                if (sb[sb.size()-1][DW+1:DW] == 2'(s) && found) p = 2'(s + 1);
            end
        end
        model_ptr = p;
    endfunction

    task automatic wait_drain(input int budget, output bit ok);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (sb.size() == 0);
    endtask

    task automatic read_cnt(input logic [1:0] ch, output logic v, output logic [CW-1:0] c);
        req = 1'b1;
        idx = ch;
        @(negedge clk);
        req = 1'b0;
        v = cnt_valid;
        c = cnt_out;
    endtask

    task automatic test_reset();
        logic          v;
        logic [CW-1:0] c;
        reset_L = 1'b0; init = 1'b1; pause = 1'b0; req = 1'b0; idx = 2'd0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({pop_o, data_out, valid_out, idx_out, cnt_valid, cnt_out, idle_out} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got pop=%b data=%h valid=%b idx=%0d cv=%b cnt=%0d idle=%b, required all 0",
                     pop_o, data_out, valid_out, idx_out, cnt_valid, cnt_out, idle_out);
        end
        reset_L = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (idle_out !== 1'b0) begin
            n_err++; $display("FAIL idle_in_init: got %b, required 0", idle_out);
        end
        @(negedge clk);
        init = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (idle_out !== 1'b1) begin
            n_err++; $display("FAIL idle_after_init: got %b, required 1", idle_out);
        end
        n_cmp++;
        if ({pop_o, valid_out, cnt_valid} !== '0) begin
            n_err++; $display("FAIL idle_outputs: got pop=%b valid=%b cv=%b, required 0", pop_o, valid_out, cnt_valid);
        end
        read_cnt(2'd2, v, c);
        n_cmp++;
        if ({v, c} !== {1'b1, 5'd0}) begin
            n_err++; $display("FAIL cnt2_after_reset: got valid=%b cnt=%0d, required valid=1 cnt=0", v, c);
        end
    endtask

    task automatic test_rr();
        logic          v;
        logic [CW-1:0] c;
        bit            ok;
        pop_log.delete();
        fq[0].push_back(6'h05); fq[0].push_back(6'h06); fq[2].push_back(6'h21);
        sb.push_back({2'd0, 6'h05}); sb.push_back({2'd2, 6'h21}); sb.push_back({2'd0, 6'h06});
        model_ptr = 2'd1;
        wait_drain(20, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rr_drain: %0d words outstanding, required 0", sb.size()); end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pop_log.size() != 3 || {pop_log[0], pop_log[1], pop_log[2]} !== 12'h141) begin
            n_err++;
            $display("FAIL rr_pop_seq: got %0d pops first=%b,%b,%b, required 0001,0100,0001",
                     pop_log.size(), pop_log[0], pop_log[1], pop_log[2]);
        end
        n_cmp++;
        if (idle_out !== 1'b1) begin n_err++; $display("FAIL rr_idle: got %b, required 1", idle_out); end
        read_cnt(2'd0, v, c);
        n_cmp++;
        if ({v, c} !== {1'b1, 5'd2}) begin n_err++; $display("FAIL rr_cnt0: got valid=%b cnt=%0d, required valid=1 cnt=2", v, c); end
        read_cnt(2'd2, v, c);
        n_cmp++;
        if ({v, c} !== {1'b1, 5'd1}) begin n_err++; $display("FAIL rr_cnt2: got valid=%b cnt=%0d, required valid=1 cnt=1", v, c); end
    endtask

    task automatic test_pause();
        logic          v;
        logic [CW-1:0] c;
        bit            ok;
        for (int n = 0; n < 4; n++)
            for (int j = 0; j < 3; j++) fq[n].push_back({2'(n), 4'(4 * n + j)});
        build_expected();
        repeat (4) @(negedge clk);
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (pop_o !== 4'b0) begin n_err++; $display("FAIL pause_pop: cycle %0d got %b, required 0000", k, pop_o); end
            @(negedge clk);
        end
        pause = 1'b0;
        wait_drain(60, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL pause_drain: %0d words outstanding, required 0", sb.size()); end
        read_cnt(2'd0, v, c);
        n_cmp++;
        if ({v, c} !== {1'b1, 5'd5}) begin n_err++; $display("FAIL pause_cnt0: got valid=%b cnt=%0d, required valid=1 cnt=5", v, c); end
        read_cnt(2'd2, v, c);
        n_cmp++;
        if ({v, c} !== {1'b1, 5'd4}) begin n_err++; $display("FAIL pause_cnt2: got valid=%b cnt=%0d, required valid=1 cnt=4", v, c); end
    endtask

    task automatic test_wrap();
        logic          v;
        logic [CW-1:0] c;
        bit            ok;
        int            vcount;
        int            cyc;
        init = 1'b1;
        @(negedge clk);
        read_cnt(2'd0, v, c);
        n_cmp++;
        if ({v, c} !== {1'b1, 5'd0}) begin n_err++; $display("FAIL req_in_init: got valid=%b cnt=%0d, required valid=1 cnt=0", v, c); end
        init = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 33; j++) fq[1].push_back({2'b01, 4'(j)});
        build_expected();
        vcount = 0;
        cyc = 0;
        while (vcount < 32 && cyc < 120) begin
            @(negedge clk);
            cyc++;
            if (valid_out === 1'b1) vcount++;
        end
        n_cmp++;
        if (vcount != 32) begin n_err++; $display("FAIL wrap_progress: got %0d captures, required 32", vcount); end
        req = 1'b1;
        idx = 2'd1;
        @(negedge clk);
        req = 1'b0;
        n_cmp++;
        if ({valid_out, cnt_valid, cnt_out} !== {1'b1, 1'b1, 5'd0}) begin
            n_err++;
            $display("FAIL wrap_same_cycle: got valid=%b cv=%b cnt=%0d, required 1 1 0", valid_out, cnt_valid, cnt_out);
        end
        wait_drain(10, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL wrap_drain: %0d words outstanding, required 0", sb.size()); end
        read_cnt(2'd1, v, c);
        n_cmp++;
        if ({v, c} !== {1'b1, 5'd1}) begin n_err++; $display("FAIL wrap_cnt1: got valid=%b cnt=%0d, required valid=1 cnt=1", v, c); end
    endtask

    task automatic test_reset_active();
        bit saw;
        for (int n = 0; n < 4; n++)
            for (int j = 0; j < 2; j++) fq[n].push_back({2'(n), 4'(8 + j)});
        build_expected();
        repeat (4) @(negedge clk);
        #1;
        n_cmp++;
        if (pop_o === 4'b0) begin n_err++; $display("FAIL ra_pop_live: got %b, required a pop", pop_o); end
        @(posedge clk);
        #2;
        reset_L = 1'b0;
        #1;
        n_cmp++;
        if ({pop_o, data_out, valid_out, idx_out, cnt_valid, cnt_out, idle_out} !== '0) begin
            n_err++;
            $display("FAIL ra_async_clear: got pop=%b data=%h valid=%b idx=%0d cv=%b cnt=%0d idle=%b, required all 0",
                     pop_o, data_out, valid_out, idx_out, cnt_valid, cnt_out, idle_out);
        end
        sb.delete();
        for (int n = 0; n < 4; n++) fq[n].delete();
        model_ptr = 2'd0;
        @(negedge clk);
        reset_L = 1'b1;
        init = 1'b1;
        repeat (2) @(negedge clk);
        init = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (valid_out !== 1'b0) saw = 1'b1;
        end
        n_cmp++;
        if (saw) begin n_err++; $display("FAIL ra_stale_valid: got valid_out=1 after reset, required 0"); end
        n_cmp++;
        if (idle_out !== 1'b1) begin n_err++; $display("FAIL ra_idle: got %b, required 1", idle_out); end
    endtask

    task automatic test_init();
        logic          v;
        logic [CW-1:0] c;
        bit            ok;
        int            vcount;
        int            cyc;
        int            rem [4];
        for (int n = 0; n < 4; n++)
            for (int j = 0; j < 4; j++) fq[n].push_back({2'(n), 4'(12 + j)});
        build_expected();
        vcount = 0;
        cyc = 0;
        while (vcount < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (valid_out === 1'b1) vcount++;
        end
        n_cmp++;
        if (vcount != 3) begin n_err++; $display("FAIL init_progress: got %0d captures, required 3", vcount); end
        init = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (pop_o !== 4'b0) begin n_err++; $display("FAIL init_pop: cycle %0d got %b, required 0000", k, pop_o); end
        end
        pause = 1'b1;
        init = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 4; n++) rem[n] = fq[n].size();
        for (int n = 0; n < 4; n++) begin
            read_cnt(2'(n), v, c);
            n_cmp++;
            if ({v, c} !== {1'b1, 5'd0}) begin
                n_err++; $display("FAIL init_cnt_clear: ch%0d got valid=%b cnt=%0d, required valid=1 cnt=0", n, v, c);
            end
        end
        pause = 1'b0;
        wait_drain(80, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL init_drain: %0d words outstanding, required 0", sb.size()); end
        for (int n = 0; n < 4; n++) begin
            read_cnt(2'(n), v, c);
            n_cmp++;
            if ({v, c} !== {1'b1, CW'(rem[n])}) begin
                n_err++; $display("FAIL init_cnt_after: ch%0d got valid=%b cnt=%0d, required valid=1 cnt=%0d", n, v, c, rem[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr();
        test_pause();
        test_wrap();
        test_reset_active();
        test_init();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d words, required 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
